// File: rtl/mult_div_unit.sv
// Multiply/divide unit for the E stage: owns HI/LO, models latency with a
// down-counter, and serves mfhi/mflo/mthi/mtlo.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] MDUOut
);

  // state | meaning
  // IDLE  | no op in flight, mt*/mf* serviced, Start accepted
  // RUN   | op in flight, counter counts down to the HI/LO write
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  state_t      state, state_nxt;
  logic [3:0]  count;
  logic [3:0]  op;
  logic [31:0] op_a, op_b;
  logic [31:0] hi, lo;
  logic        is_muldiv, is_div_req;
  logic        start_ok, done;

  logic        div_ovf, div_by_zero;
  logic [31:0] div_b;
  logic [63:0] prod_s, prod_u;
  logic [31:0] quot_s, rem_s;
  logic [31:0] res_hi, res_lo;
  logic        res_write;

  assign is_muldiv  = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU) ||
                      (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
  assign is_div_req = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);
  assign Busy       = (state == RUN);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and one-cycle control strobes
  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (Start && is_muldiv) begin
          start_ok  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (count == 4'd1) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Arithmetic on the latched operands; the divisor is forced to 1 for the
  // zero and INT_MIN/-1 cases so the divider never sees an undefined input.
  always_comb begin
    div_by_zero = (op_b == 32'h0);
    div_ovf     = (op == OP_DIV) && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
    div_b       = (div_by_zero || div_ovf) ? 32'd1 : op_b;
    prod_s      = 64'($signed(op_a)) * 64'($signed(op_b));
    prod_u      = {32'h0, op_a} * {32'h0, op_b};
    quot_s      = 32'($signed(op_a) / $signed(div_b));
    rem_s       = 32'($signed(op_a) % $signed(div_b));
    res_hi      = hi;
    res_lo      = lo;
    res_write   = 1'b1;
    case (op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        if (div_ovf) begin
          res_lo = 32'h8000_0000;
          res_hi = 32'h0;
        end else begin
          res_lo = quot_s;
          res_hi = rem_s;
        end
        res_write = !div_by_zero;
      end
      OP_DIVU: begin
        res_lo    = op_a / div_b;
        res_hi    = op_a % div_b;
        res_write = !div_by_zero;
      end
      default: res_write = 1'b0;
    endcase
  end

  // Operand latch, latency counter and HI/LO registers
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 4'd0;
      op    <= 4'd0;
      op_a  <= 32'h0;
      op_b  <= 32'h0;
      hi    <= 32'h0;
      lo    <= 32'h0;
    end else if (start_ok) begin
      op    <= MDUOp;
      op_a  <= A;
      op_b  <= B;
      count <= is_div_req ? DIV_N : MULT_N;
    end else if (state == RUN) begin
      count <= count - 4'd1;
      if (done && res_write) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end else begin
      if (MDUOp == OP_MTHI) hi <= A;
      if (MDUOp == OP_MTLO) lo <= A;
    end
  end

  // Register read port for mfhi/mflo
  always_comb begin
    MDUOut = 32'h0;
    if (MDUOp == OP_MFHI)      MDUOut = hi;
    else if (MDUOp == OP_MFLO) MDUOut = lo;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit with a behavioural HI/LO model.
module tb_mult_div_unit;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  localparam logic [3:0] NUL = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
  localparam logic [3:0] MFHI = 4'd5, MFLO = 4'd6, MTHI = 4'd7, MTLO = 4'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  MDUOp;
  logic        Start;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] MDUOut;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] m_hi, m_lo;

  mult_div_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .MDUOp(MDUOp), .Start(Start),
    .A(A), .B(B), .Busy(Busy), .MDUOut(MDUOut)
  );

  always #5 clk = ~clk;

  // Reference: architectural effect of one mul/div instruction on HI/LO.
  task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r, p;
    longint unsigned pu;
    logic [63:0]     v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MULT: begin
        p = sa * sb; v = p;
        m_hi = v[63:32]; m_lo = v[31:0];
      end
      MULTU: begin
        pu = longint'({32'h0, a}) * longint'({32'h0, b}); v = pu;
        m_hi = v[63:32]; m_lo = v[31:0];
      end
      DIV: if (b != 0) begin
        q = sa / sb; r = sa % sb;
        v = q; m_lo = v[31:0];
        v = r; m_hi = v[31:0];
      end
      DIVU: if (b != 0) begin
        m_lo = a / b; m_hi = a % b;
      end
      default: ;
    endcase
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic read_hilo(input string tag);
    MDUOp = MFHI; #1;
    n_total++;
    if (MDUOut !== m_hi) $display("FAIL %s hi: got %h want %h", tag, MDUOut, m_hi);
    else n_pass++;
    MDUOp = MFLO; #1;
    n_total++;
    if (MDUOut !== m_lo) $display("FAIL %s lo: got %h want %h", tag, MDUOut, m_lo);
    else n_pass++;
    MDUOp = NUL;
  endtask

  // Issue one mul/div; while busy drive run_op/run_start and scramble A/B.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] run_op, input logic run_start, input string tag);
    int          n_exp, busy_cnt;
    logic [31:0] old_hi, old_lo;
    n_exp  = (op == DIV || op == DIVU) ? DIV_CYCLES : MULT_CYCLES;
    old_hi = m_hi;
    old_lo = m_lo;
    MDUOp = op; Start = 1'b1; A = a; B = b;
    step();
    Start = run_start; MDUOp = run_op; A = $urandom; B = $urandom;
    busy_cnt = 0;
    while (Busy === 1'b1 && busy_cnt < 40) begin
      busy_cnt++;
      #1;
      if (run_op == MFHI || run_op == MFLO) begin
        n_total++;
        if (MDUOut !== ((run_op == MFHI) ? old_hi : old_lo))
          $display("FAIL %s read_while_busy: got %h want %h", tag, MDUOut,
                   (run_op == MFHI) ? old_hi : old_lo);
        else n_pass++;
      end
      step();
      A = $urandom; B = $urandom;
    end
    Start = 1'b0; MDUOp = NUL;
    n_total++;
    if (busy_cnt != n_exp) $display("FAIL %s busy_cycles: got %0d want %0d", tag, busy_cnt, n_exp);
    else n_pass++;
    model_op(op, a, b);
    read_hilo(tag);
  endtask

  task automatic do_mt(input logic [3:0] op, input logic [31:0] a);
    MDUOp = op; A = a;
    step();
    MDUOp = NUL;
    if (op == MTHI) m_hi = a;
    else m_lo = a;
  endtask

  task automatic test_reset();
    reset = 1'b1; Start = 1'b0; MDUOp = NUL; A = 32'h0; B = 32'h0;
    step(); step();
    reset = 1'b0;
    m_hi = 32'h0; m_lo = 32'h0;
    n_total++;
    if (Busy !== 1'b0) $display("FAIL reset busy: got %b want 0", Busy);
    else n_pass++;
    read_hilo("reset");
  endtask

  task automatic test_mult();
    do_op(MULT,  32'hFFFFFFFD, 32'd5, MFLO, 1'b0, "mult_neg");
    n_total++;
    if (m_lo !== 32'hFFFFFFF1 || m_hi !== 32'hFFFFFFFF)
      $display("FAIL mult_neg model: got %h_%h want ffffffff_fffffff1", m_hi, m_lo);
    else n_pass++;
    do_op(MULTU, 32'hFFFFFFFF, 32'd2, MFHI, 1'b0, "multu");
    do_op(MULT,  32'hFFFFFFFF, 32'd2, NUL,  1'b0, "mult_m1x2");
  endtask

  task automatic test_div();
    do_op(DIV,  32'hFFFFFFF9, 32'd2, MFHI, 1'b0, "div_neg");
    do_op(DIVU, 32'd7,        32'd2, NUL,  1'b0, "divu");
    do_op(DIV,  32'h80000000, 32'hFFFFFFFF, NUL, 1'b0, "div_ovf");
    do_op(DIV,  32'd7, 32'hFFFFFFFE, NUL, 1'b0, "div_negdivisor");
  endtask

  task automatic test_div_zero();
    do_mt(MTHI, 32'd1234);
    read_hilo("mthi");
    do_op(DIVU, 32'd99, 32'd0, NUL, 1'b0, "divu_zero");
    do_op(DIV,  32'hFFFFFF00, 32'd0, NUL, 1'b0, "div_zero");
  endtask

  task automatic test_ignored();
    do_mt(MTLO, 32'hA5A5_0001);
    do_op(MULT, 32'd2, 32'd3, MTLO, 1'b0, "mtlo_in_run");
    do_op(DIV, 32'd100, 32'd7, MTHI, 1'b0, "mthi_in_run");
    do_op(DIV, 32'd100, 32'd9, MULT, 1'b1, "start_in_run");
    MDUOp = MFHI; Start = 1'b1;
    step();
    Start = 1'b0; MDUOp = NUL;
    n_total++;
    if (Busy !== 1'b0) $display("FAIL start_non_muldiv busy: got %b want 0", Busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    do_mt(MTLO, 32'hDEAD_BEEF);
    MDUOp = DIV; Start = 1'b1; A = 32'hFFFFFFF9; B = 32'd2;
    step();
    Start = 1'b0; MDUOp = NUL;
    step(); step();
    n_total++;
    if (Busy !== 1'b1) $display("FAIL rst_mid busy_before: got %b want 1", Busy);
    else n_pass++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_hi = 32'h0; m_lo = 32'h0;
    n_total++;
    if (Busy !== 1'b0) $display("FAIL rst_mid busy_after: got %b want 0", Busy);
    else n_pass++;
    read_hilo("rst_mid");
    do_op(MULT, 32'd7, 32'hFFFFFFFA, NUL, 1'b0, "after_rst");
  endtask

  task automatic test_back_to_back();
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      op = 4'($urandom_range(1, 4));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      do_op(op, a, b, ($urandom_range(0, 1) == 0) ? MFHI : MFLO, 1'b0, "random");
      if ($urandom_range(0, 3) == 0) begin
        do_mt(($urandom_range(0, 1) == 0) ? MTHI : MTLO, $urandom);
        read_hilo("random_mt");
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_ignored();
    test_reset_mid_op();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
